// File: rtl/tail_light_pkg.sv
// Shared types and helpers for the rear-lamp sequencer.
// TAIL_LIGHT_ALARM_EN adds the ALARM state to the state enum.
package tail_light_pkg;

  localparam int TL_MAX_LAMPS = 32;

`ifdef TAIL_LIGHT_ALARM_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TURN_L = 3'd1,
    TURN_R = 3'd2,
    HAZARD = 3'd3,
    ALARM  = 3'd4
  } tl_state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TURN_L = 3'd1,
    TURN_R = 3'd2,
    HAZARD = 3'd3
  } tl_state_t;
`endif

  // Thermometer mask with the lowest s bits set; callers slice to LAMPS.
  function automatic logic [TL_MAX_LAMPS-1:0] thermo(input int unsigned s);
    logic [TL_MAX_LAMPS-1:0] one_v;
    one_v = {{(TL_MAX_LAMPS-1){1'b0}}, 1'b1};
    return (one_v << s) - one_v;
  endfunction

endpackage

// File: rtl/tail_light_tick.sv
// Step prescaler: pulses tick every DIV enabled cycles, restarts on clear.
module tail_light_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV == 1) begin : g_nodiv
      logic unused_s;
      assign unused_s = ^{clk, reset_n, clear};
      assign tick     = enable;
    end else begin : g_div
      localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
      localparam logic [PW-1:0] P_ONE  = PW'(1);
      logic [PW-1:0] p_r;

      assign tick = enable && (p_r == P_LAST);

      // Prescaler count: wraps at the tick, forced to zero by clear.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          p_r <= {PW{1'b0}};
        end else if (clear) begin
          p_r <= {PW{1'b0}};
        end else if (enable) begin
          p_r <= tick ? {PW{1'b0}} : (p_r + P_ONE);
        end else begin
          p_r <= p_r;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/tail_light_seq.sv
// Rear-lamp sequencer: turn sweep, brake/fog on the idle side, hazard mode.
// TAIL_LIGHT_ALARM_EN enables the alarm blink state.
module tail_light_seq
  import tail_light_pkg::*;
#(
  parameter int LAMPS = 3,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             left,
  input  logic             right,
  input  logic             brake,
  input  logic             fog,
  input  logic             alarm,
  output logic [LAMPS-1:0] l_lamp,
  output logic [LAMPS-1:0] r_lamp,
  output logic             busy
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam logic [SW-1:0] S_ZERO = {SW{1'b0}};
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [SW-1:0] S_LAST = SW'(LAMPS);
  localparam logic [LAMPS-1:0] ALL_ON  = {LAMPS{1'b1}};
  localparam logic [LAMPS-1:0] ALL_OFF = {LAMPS{1'b0}};
  localparam logic [LAMPS-1:0] INNER   = LAMPS'(1);

  tl_state_t state_r, state_next_s, req_state_s;
  logic [SW-1:0] s_r, s_next_s;
  logic tick_s, clear_s, enable_s;
  logic [TL_MAX_LAMPS-1:0] thermo_s;
  logic [LAMPS-1:0] sweep_s, static_s, l_next_s, r_next_s;
  logic phase_next_s;

`ifdef TAIL_LIGHT_ALARM_EN
  logic phase_r;
`else
  logic alarm_unused_s;
  assign alarm_unused_s = alarm;
`endif

  assign enable_s = (state_r != IDLE);
  assign clear_s  = (state_r == IDLE) || (state_next_s != state_r);

  tail_light_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear_s),
    .enable  (enable_s),
    .tick    (tick_s)
  );

  // Request priority as seen at a decision point.
  always_comb begin
    req_state_s = IDLE;
`ifdef TAIL_LIGHT_ALARM_EN
    if (alarm) req_state_s = ALARM;
    else
`endif
    if (left && right) req_state_s = HAZARD;
    else if (left)     req_state_s = TURN_L;
    else if (right)    req_state_s = TURN_R;
    else               req_state_s = IDLE;
  end

  // Next state and step; sweep decisions only happen at the end of the gap.
  always_comb begin
    state_next_s = state_r;
    s_next_s     = s_r;
    case (state_r)
      IDLE: begin
        state_next_s = req_state_s;
        s_next_s     = (req_state_s == IDLE) ? S_ZERO : S_ONE;
`ifdef TAIL_LIGHT_ALARM_EN
        if (req_state_s == ALARM) s_next_s = S_ZERO;
        else s_next_s = s_next_s;
`endif
      end
      TURN_L, TURN_R, HAZARD: begin
`ifdef TAIL_LIGHT_ALARM_EN
        if (alarm) begin
          state_next_s = ALARM;
          s_next_s     = S_ZERO;
        end else
`endif
        if (tick_s) begin
          if (s_r == S_ZERO) begin
            state_next_s = req_state_s;
            s_next_s     = (req_state_s == IDLE) ? S_ZERO : S_ONE;
          end else if (s_r == S_LAST) begin
            s_next_s = S_ZERO;
          end else begin
            s_next_s = s_r + S_ONE;
          end
        end else begin
          state_next_s = state_r;
          s_next_s     = s_r;
        end
      end
`ifdef TAIL_LIGHT_ALARM_EN
      ALARM: begin
        state_next_s = alarm ? ALARM : IDLE;
        s_next_s     = S_ZERO;
      end
`endif
      default: begin
        state_next_s = IDLE;
        s_next_s     = S_ZERO;
      end
    endcase
  end

  // Blink phase: starts on at alarm entry, toggles every step.
  always_comb begin
    phase_next_s = 1'b0;
`ifdef TAIL_LIGHT_ALARM_EN
    if (state_next_s == ALARM) begin
      if (state_r != ALARM) phase_next_s = 1'b1;
      else if (tick_s)      phase_next_s = ~phase_r;
      else                  phase_next_s = phase_r;
    end else begin
      phase_next_s = 1'b0;
    end
`endif
  end

  // Lamp drive computed from the upcoming state so outputs follow the same edge.
  always_comb begin
    thermo_s = thermo(32'(s_next_s));
    sweep_s  = thermo_s[LAMPS-1:0];
    if (brake)    static_s = ALL_ON;
    else if (fog) static_s = INNER;
    else          static_s = ALL_OFF;
    l_next_s = static_s;
    r_next_s = static_s;
    case (state_next_s)
      IDLE:   begin l_next_s = static_s; r_next_s = static_s; end
      TURN_L: begin l_next_s = sweep_s;  r_next_s = static_s; end
      TURN_R: begin l_next_s = static_s; r_next_s = sweep_s;  end
      HAZARD: begin l_next_s = sweep_s;  r_next_s = sweep_s;  end
`ifdef TAIL_LIGHT_ALARM_EN
      ALARM: begin
        l_next_s = phase_next_s ? ALL_ON : ALL_OFF;
        r_next_s = phase_next_s ? ALL_ON : ALL_OFF;
      end
`endif
      default: begin l_next_s = ALL_OFF; r_next_s = ALL_OFF; end
    endcase
  end

  // State, step and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      s_r     <= S_ZERO;
      l_lamp  <= ALL_OFF;
      r_lamp  <= ALL_OFF;
      busy    <= 1'b0;
`ifdef TAIL_LIGHT_ALARM_EN
      phase_r <= 1'b0;
`endif
    end else begin
      state_r <= state_next_s;
      s_r     <= s_next_s;
      l_lamp  <= l_next_s;
      r_lamp  <= r_next_s;
      busy    <= (state_next_s != IDLE);
`ifdef TAIL_LIGHT_ALARM_EN
      phase_r <= phase_next_s;
`endif
    end
  end

endmodule
